serial_adder: RTL

Bit-serial N-bit adder for area-constrained datapaths: it adds two N-bit operands one bit per clock through a single 1-bit full-adder cell and a registered carry. It sits directly downstream of the team's 1-bit full adder and consumes its sum and carry outputs each cycle. A start/busy/done handshake connects it to a controlling FSM.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_fa_cell.sv | 16 +
 rtl/serial_adder.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding for the bit-serial adder
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - 1-bit combinational full adder cell
module fa_cell (
   output logic s,
   output logic c,
   input  logic a,
   input  logic b,
   input  logic cin
);

   // Sum is the parity of the three inputs, carry is their majority.
   always_comb begin
      s = a ^ b ^ cin;
      c = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder with start/busy/done handshake
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int CNT_W = $clog2(N);

   state_t           state;
   state_t           state_nxt;
   logic [N-1:0]     ra;
   logic [N-1:0]     rb;
   // Partial sum holds only the N-1 bits already computed; the current
   // cell output completes it into a full N-bit word in rs_nxt.
   logic [N-2:0]     rs;
   logic [N-1:0]     rs_nxt;
   logic             cy;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   fa_cell u_fa_cell (
      .s   (fa_s),
      .c   (fa_c),
      .a   (ra[0]),
      .b   (rb[0]),
      .cin (cy)
   );

   assign rs_nxt   = {fa_s, rs};
   assign last_bit = (cnt == CNT_W'(N - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept only in IDLE, finish after the MSB, DONE lasts one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, bit-serial datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra   <= '0;
         rb   <= '0;
         rs   <= '0;
         cy   <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt == ST_SHIFT);
         done <= (state_nxt == ST_DONE);
         if (state == ST_IDLE && start) begin
            ra  <= a;
            rb  <= b;
            cy  <= cin;
            cnt <= '0;
         end else if (state == ST_SHIFT) begin
            ra <= {1'b0, ra[N-1:1]};
            rb <= {1'b0, rb[N-1:1]};
            rs <= rs_nxt[N-1:1];
            cy <= fa_c;
            if (last_bit) begin
               sum  <= rs_nxt;
               cout <= fa_c;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
